// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the RV32 pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazardStateT;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
    } pipeCtlT;

    // x0 is hard-wired to zero, so a write to it never produces a value worth forwarding.
    function automatic logic regMatch(
        input logic       regWrite,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return regWrite && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_select.sv
// EX-stage operand forwarding select for one source register; M beats W.
module forward_select
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] fwdSel
);

    always_comb begin
        // NOTE: assign a default before any branch so the combinational block never infers a latch.
        fwdSel = FWD_RD;
        if (regMatch(RegWriteM, RdM, RsE)) begin
            fwdSel = FWD_MEM;
        end else if (regMatch(RegWriteW, RdW, RsE)) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch flushes,
// data-memory freeze with timeout, and saturating stall/flush event counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazardStateT      stateQ, stateD;
    logic [TMO_W-1:0] waitCntQ, waitCntD;
    logic             memErrQ;
    logic [CNT_W-1:0] stallCntQ, flushCntQ;

    logic             lwStall;
    logic             mWait;
    logic             pcFlush;
    pipeCtlT          ctl;
    logic [1:0]       fwdA, fwdB;

    forward_select u_fwdA (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwdSel    (fwdA)
    );

    forward_select u_fwdB (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwdSel    (fwdB)
    );

    assign lwStall = (ResultSrcE == RESULTSRC_LOAD) && (RdE != 5'd0)
                     && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mWait   = dmem_req_M && !dmem_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            stateQ   <= RUN;
            waitCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCntQ;
        case (stateQ)
            RUN: begin
                if (mWait) begin
                    stateD   = MEM_WAIT;
                    waitCntD = TMO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    stateD   = RUN;
                    waitCntD = '0;
                end else if (waitCntQ == TMO_W'(TIMEOUT)) begin
                    stateD = ERROR;
                end else begin
                    waitCntD = waitCntQ + TMO_W'(1);
                end
            end
            ERROR: begin
                stateD = ERROR;
            end
            default: begin
                stateD   = RUN;
                waitCntD = '0;
            end
        endcase
    end

    // A held E stage keeps PCSrcE/lwStall alive, so they act on the release cycle.
    always_comb begin
        ctl     = '0;
        pcFlush = 1'b0;
        if (!rst) begin
            if ((stateQ == ERROR) || mWait) begin
                ctl.stallF = 1'b1;
                ctl.stallD = 1'b1;
                ctl.stallE = 1'b1;
                ctl.stallM = 1'b1;
            end else if (PCSrcE) begin
                ctl.flushD = 1'b1;
                ctl.flushE = 1'b1;
                pcFlush    = 1'b1;
            end else if (lwStall) begin
                ctl.stallF = 1'b1;
                ctl.stallD = 1'b1;
                ctl.flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memErrQ   <= 1'b0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            memErrQ <= memErrQ | (stateD == ERROR);
            if (ctl.stallF && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (pcFlush && (flushCntQ != '1)) begin
                flushCntQ <= flushCntQ + CNT_W'(1);
            end
        end
    end

    assign StallF    = ctl.stallF;
    assign StallD    = ctl.stallD;
    assign StallE    = ctl.stallE;
    assign StallM    = ctl.stallM;
    assign FlushD    = ctl.flushD;
    assign FlushE    = ctl.flushE;
    assign ForwardAE = rst ? FWD_RD : fwdA;
    assign ForwardBE = rst ? FWD_RD : fwdB;
    assign mem_err   = memErrQ;
    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;

endmodule
